// File: rtl/sll_multicycle.sv
// Iterative 32-bit logical left shifter: one binary-weighted stage (16,8,4,2,1)
// per cycle, result plus a one-cycle ready pulse six cycles after start.
module sll_multicycle (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] work_reg, work_next;
  logic [4:0]  amt_reg, amt_next;
  logic [2:0]  stage_reg, stage_next;
  logic [31:0] result_reg, result_next;

  // Candidate value for every stage; the active stage index picks one per cycle.
  logic [31:0] stage_shift [5];
  logic [31:0] work_stepped;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      assign stage_shift[gi] = amt_reg[gi] ? (work_reg << (2 ** gi)) : work_reg;
    end
  endgenerate

  always_comb begin
    work_stepped = work_reg;
    for (int i = 0; i < 5; i++) begin
      if (stage_reg == 3'(i)) begin
        work_stepped = stage_shift[i];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    amt_next    = amt_reg;
    stage_next  = stage_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (ctrl_start) begin
          work_next  = data_operandA;
          amt_next   = ctrl_shiftamt;
          stage_next = 3'd4;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        work_next = work_stepped;
        if (stage_reg == 3'd0) begin
          result_next = work_stepped;
          state_next  = DONE;
        end else begin
          stage_next = stage_reg - 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      amt_reg    <= '0;
      stage_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      amt_reg    <= amt_next;
      stage_reg  <= stage_next;
      result_reg <= result_next;
    end
  end

  assign data_result    = result_reg;
  assign data_resultRDY = (state_reg == DONE);
  assign busy           = (state_reg == SHIFT);

endmodule

// File: tb/tb_sll_multicycle.sv
// Self-checking bench for sll_multicycle: vector table, multi-cycle corner
// sequences and random jobs, results matched through an expected-value queue.
module tb_sll_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_start = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [4:0]  ctrl_shiftamt = '0;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  sll_multicycle dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int rdy_count = 0;
  int starts = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] op;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every RDY pulse must match the oldest outstanding job.
  always @(negedge clock) begin
    if (reset === 1'b0 && data_resultRDY === 1'b1) begin
      rdy_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got rdy with result %h, required no rdy at %0t",
                 data_result, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", data_result, e);
        $display("job %0d result %h expected %h", rdy_count, data_result, e);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Starts a job in the current cycle and checks busy/RDY through cycle 6;
  // returns inside the DONE cycle so the next call runs back-to-back.
  task automatic run_job(input logic [31:0] op, input logic [4:0] amt,
                         input logic [31:0] exp, input bit noisy);
    data_operandA = op;
    ctrl_shiftamt = amt;
    ctrl_start    = 1'b1;
    exp_q.push_back(exp);
    starts++;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (noisy && c < 6) begin
        ctrl_start    = 1'($urandom_range(0, 1));
        data_operandA = $urandom;
        ctrl_shiftamt = 5'($urandom);
      end else begin
        ctrl_start = 1'b0;
      end
      @(negedge clock);
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c < 6));
      check($sformatf("rdy_c%0d", c), 32'(data_resultRDY), 32'(c == 6));
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00};
    vecs[2] = '{32'h8000_0000, 5'd1,  32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[4] = '{32'h1234_5678, 5'd21, 32'hCF00_0000};
    vecs[5] = '{32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50};
    vecs[6] = '{32'h0000_0003, 5'd30, 32'hC000_0000};
    vecs[7] = '{32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_result", data_result, 32'd0);
    tick();

    // Vector table, issued back-to-back from the DONE cycle
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].op, vecs[i].amt, vecs[i].exp, 1'b0);
    end
    tick();

    // Start ignored while shifting, then back-to-back restart in cycle 6
    data_operandA = 32'h0000_000F;
    ctrl_shiftamt = 5'd4;
    ctrl_start    = 1'b1;
    exp_q.push_back(32'h0000_00F0);
    starts++;
    tick(); ctrl_start = 1'b0;
    tick();
    tick(); ctrl_start = 1'b1; data_operandA = 32'hDEAD_BEEF; ctrl_shiftamt = 5'd9;
    @(negedge clock);
    check("ignored_busy_c3", 32'(busy), 32'd1);
    tick(); ctrl_start = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check("ignored_rdy_c6", 32'(data_resultRDY), 32'd1);
    run_job(32'h0000_0001, 5'd2, 32'h0000_0004, 1'b0);
    tick();

    // Reset mid-shift aborts the job
    data_operandA = 32'h0000_00FF;
    ctrl_shiftamt = 5'd1;
    ctrl_start    = 1'b1;
    tick(); ctrl_start = 1'b0;
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(data_resultRDY), 32'd0);
    check("abort_result", data_result, 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clock);
      check("abort_no_rdy", 32'(data_resultRDY), 32'd0);
    end

    // Reset and start together: the start is dropped
    tick();
    reset = 1'b1; ctrl_start = 1'b1; data_operandA = 32'h5; ctrl_shiftamt = 5'd1;
    tick();
    reset = 1'b0; ctrl_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      check("rst_start_busy", 32'(busy), 32'd0);
      check("rst_start_rdy", 32'(data_resultRDY), 32'd0);
      tick();
    end

    // Random jobs with random gaps (gap 0 restarts from DONE)
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] op;
      logic [4:0]  amt;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        ctrl_start = 1'b0;
      end
      op  = $urandom;
      amt = 5'($urandom);
      run_job(op, amt, op << amt, 1'b1);
    end
    tick();
    tick();

    check("rdy_count", 32'(rdy_count), 32'(starts));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
